// File: rtl/mem_cmd_issuer_if.sv
// Bundle of the producer command, memory request and read-response channels
// seen by mem_cmd_issuer. The master side is the issuer, the slave side is its surroundings.
interface mem_cmd_issuer_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr_rd;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [WIDTH-1:0]      cmd_wdata;

  logic                  valid;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic                  ready;
  logic [WIDTH-1:0]      rdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_rdata;
  logic [ADDR_WIDTH-1:0] rsp_addr;

  modport master (
    input  cmd_valid, cmd_wr_rd, cmd_addr, cmd_wdata, ready, rdata, rsp_ready,
    output cmd_ready, valid, wr_rd, addr, wdata, rsp_valid, rsp_rdata, rsp_addr
  );

  modport slave (
    output cmd_valid, cmd_wr_rd, cmd_addr, cmd_wdata, ready, rdata, rsp_ready,
    input  cmd_ready, valid, wr_rd, addr, wdata, rsp_valid, rsp_rdata, rsp_addr
  );
endinterface

// File: rtl/mem_cmd_issuer.sv
// Queues producer commands in a small FIFO and issues them one at a time on the
// memory valid/ready port; read data returns on a response channel, stalled requests time out.
module mem_cmd_issuer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_cmd_issuer_if.master bus,
  output logic             timeout_err,
  output logic             busy
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("mem_cmd_issuer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_cmd_issuer: TIMEOUT must be >= 2");
  end
  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("mem_cmd_issuer: DEPTH exceeds the ADDR_WIDTH address range");
  end

  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  cmd_t                  r_fifo [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  state_t                r_state;
  logic [TW-1:0]         r_timer;
  logic                  r_valid;
  logic                  r_wr_rd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_rsp_valid;
  logic [WIDTH-1:0]      r_rsp_rdata;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic                  r_timeout_err;

  logic                  w_push;
  logic                  w_pop;
  cmd_t                  w_head;

  // cmd_ready follows count only, so a full FIFO refuses a push even when a pop lands on the same edge
  assign bus.cmd_ready = rst & (r_count < FULL_CNT);
  assign w_push        = bus.cmd_valid & bus.cmd_ready;
  assign w_pop         = (r_state == S_IDLE) && (r_count != '0);
  assign w_head        = r_fifo[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= {bus.cmd_wr_rd, bus.cmd_addr, bus.cmd_wdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_valid       <= 1'b0;
      r_wr_rd       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_addr    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_wr_rd <= w_head.wr_rd;
            r_addr  <= w_head.addr;
            r_wdata <= w_head.wdata;
            r_valid <= 1'b1;
            r_timer <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // ready is checked before the timer, so a completion on the final tick is not an error
          if (bus.ready) begin
            r_valid <= 1'b0;
            if (r_wr_rd) begin
              r_state <= S_IDLE;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= bus.rdata;
              r_rsp_addr  <= r_addr;
              r_state     <= S_RESP;
            end
          end else if (r_timer == LAST_TICK) begin
            r_valid       <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.valid     = r_valid;
  assign bus.wr_rd     = r_wr_rd;
  assign bus.addr      = r_addr;
  assign bus.wdata     = r_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_addr  = r_rsp_addr;
  assign timeout_err   = r_timeout_err;
  assign busy          = (r_state != S_IDLE) | (r_count != '0);
endmodule

// File: tb/tb_mem_cmd_issuer.sv
// Directed bench for mem_cmd_issuer: reset, write/read, FIFO full, timeout,
// response backpressure and asynchronous reset during a request.
module tb_mem_cmd_issuer;
  logic clk;
  logic rst;
  logic timeout_err;
  logic busy;
  int   n_checks;
  int   n_fails;

  mem_cmd_issuer_if #(.WIDTH(16), .ADDR_WIDTH(5)) bus ();

  mem_cmd_issuer #(
    .WIDTH(16), .DEPTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .timeout_err(timeout_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic wr, input logic [4:0] a, input logic [15:0] d);
    bus.cmd_valid = v;
    bus.cmd_wr_rd = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    set_cmd(1'b1, 1'b1, 5'd7, 16'hFFFF);
    bus.ready     = 1'b0;
    bus.rdata     = '0;
    bus.rsp_ready = 1'b1;

    // reset held with a command offered
    repeat (3) tick();
    check_eq("rst_valid",     32'(bus.valid),     0);
    check_eq("rst_wr_rd",     32'(bus.wr_rd),     0);
    check_eq("rst_addr",      32'(bus.addr),      0);
    check_eq("rst_wdata",     32'(bus.wdata),     0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check_eq("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    check_eq("rst_rsp_addr",  32'(bus.rsp_addr),  0);
    check_eq("rst_terr",      32'(timeout_err),   0);
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    check_eq("rst_busy",      32'(busy),          0);
    set_cmd(1'b0, 1'b0, 5'd0, 16'h0);
    rst = 1'b1;
    #1;
    check_eq("rel_cmd_ready", 32'(bus.cmd_ready), 1);
    check_eq("rel_busy",      32'(busy),          0);

    // write then read to address 5
    tick();
    set_cmd(1'b1, 1'b1, 5'd5, 16'hA5A5);
    tick();
    check_eq("wr_not_yet_valid", 32'(bus.valid), 0);
    check_eq("wr_busy",          32'(busy),      1);
    set_cmd(1'b1, 1'b0, 5'd5, 16'h0);
    tick();
    set_cmd(1'b0, 1'b0, 5'd0, 16'h0);
    check_eq("wr_valid", 32'(bus.valid), 1);
    check_eq("wr_wr_rd", 32'(bus.wr_rd), 1);
    check_eq("wr_addr",  32'(bus.addr),  5);
    check_eq("wr_wdata", 32'(bus.wdata), 32'hA5A5);
    tick();
    check_eq("wr_hold_valid", 32'(bus.valid), 1);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    check_eq("wr_done_valid", 32'(bus.valid), 0);
    tick();
    check_eq("rd_valid", 32'(bus.valid), 1);
    check_eq("rd_wr_rd", 32'(bus.wr_rd), 0);
    check_eq("rd_addr",  32'(bus.addr),  5);
    bus.ready     = 1'b1;
    bus.rdata     = 16'hA5A5;
    bus.rsp_ready = 1'b0;
    tick();
    bus.ready = 1'b0;
    bus.rdata = 16'h0000;
    check_eq("rd_rsp_valid", 32'(bus.rsp_valid), 1);
    check_eq("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'hA5A5);
    check_eq("rd_rsp_addr",  32'(bus.rsp_addr),  5);
    check_eq("rd_req_drop",  32'(bus.valid),     0);

    // response backpressure, with a write queued meanwhile
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_cmd(1'b1, 1'b1, 5'd7, 16'h0707);
      tick();
      if (i == 0) set_cmd(1'b0, 1'b0, 5'd0, 16'h0);
      check_eq("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      check_eq("bp_rsp_rdata", 32'(bus.rsp_rdata), 32'hA5A5);
      check_eq("bp_no_issue",  32'(bus.valid),     0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check_eq("bp_rsp_clear", 32'(bus.rsp_valid), 0);
    tick();
    check_eq("bp_next_valid", 32'(bus.valid), 1);
    check_eq("bp_next_addr",  32'(bus.addr),  7);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    check_eq("bp_next_done", 32'(bus.valid), 0);
    tick();
    check_eq("bp_idle_busy", 32'(busy), 0);

    // FIFO full: five writes while memory stalls
    for (int k = 0; k < 5; k++) begin
      set_cmd(1'b1, 1'b1, 5'(10 + k), 16'(16'h100 + k));
      tick();
    end
    check_eq("full_cmd_ready", 32'(bus.cmd_ready), 0);
    set_cmd(1'b1, 1'b1, 5'd15, 16'hDEAD);
    tick();
    check_eq("full_still_full", 32'(bus.cmd_ready), 0);
    tick();
    set_cmd(1'b0, 1'b0, 5'd0, 16'h0);
    check_eq("full_head_valid", 32'(bus.valid), 1);
    check_eq("full_head_addr",  32'(bus.addr),  10);
    bus.ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      check_eq("full_bubble", 32'(bus.valid), 0);
      tick();
      check_eq("full_order_valid", 32'(bus.valid), 1);
      check_eq("full_order_addr",  32'(bus.addr),  32'(10 + k));
      check_eq("full_order_wdata", 32'(bus.wdata), 32'(16'h100 + k));
    end
    tick();
    bus.ready = 1'b0;
    check_eq("full_drained_busy", 32'(busy), 0);

    // timeout on a read to address 3, with a write queued behind it
    set_cmd(1'b1, 1'b0, 5'd3, 16'h0);
    tick();
    set_cmd(1'b0, 1'b0, 5'd0, 16'h0);
    tick();
    check_eq("to_valid", 32'(bus.valid), 1);
    check_eq("to_addr",  32'(bus.addr),  3);
    set_cmd(1'b1, 1'b1, 5'd9, 16'h0909);
    tick();
    set_cmd(1'b0, 1'b0, 5'd0, 16'h0);
    check_eq("to_wait_valid", 32'(bus.valid), 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      check_eq("to_wait_valid", 32'(bus.valid),   1);
      check_eq("to_wait_terr",  32'(timeout_err), 0);
    end
    tick();
    check_eq("to_drop_valid", 32'(bus.valid),     0);
    check_eq("to_terr_pulse", 32'(timeout_err),   1);
    check_eq("to_no_rsp",     32'(bus.rsp_valid), 0);
    tick();
    check_eq("to_terr_clear", 32'(timeout_err),   0);
    check_eq("to_next_valid", 32'(bus.valid),     1);
    check_eq("to_next_addr",  32'(bus.addr),      9);
    check_eq("to_no_rsp2",    32'(bus.rsp_valid), 0);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;

    // ready on the final timeout tick wins
    set_cmd(1'b1, 1'b0, 5'd4, 16'h0);
    tick();
    set_cmd(1'b0, 1'b0, 5'd0, 16'h0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check_eq("edge_still_valid", 32'(bus.valid), 1);
    bus.ready = 1'b1;
    bus.rdata = 16'h1234;
    tick();
    bus.ready = 1'b0;
    check_eq("edge_no_terr",    32'(timeout_err),   0);
    check_eq("edge_rsp_valid",  32'(bus.rsp_valid), 1);
    check_eq("edge_rsp_rdata",  32'(bus.rsp_rdata), 32'h1234);
    check_eq("edge_rsp_addr",   32'(bus.rsp_addr),  4);
    tick();
    check_eq("edge_rsp_clear",  32'(bus.rsp_valid), 0);

    // asynchronous reset while a request is outstanding and commands are queued
    set_cmd(1'b1, 1'b1, 5'd1, 16'h1111);
    tick();
    set_cmd(1'b1, 1'b1, 5'd2, 16'h2222);
    tick();
    set_cmd(1'b1, 1'b1, 5'd3, 16'h3333);
    tick();
    set_cmd(1'b0, 1'b0, 5'd0, 16'h0);
    check_eq("ar_pre_valid", 32'(bus.valid), 1);
    #2 rst = 1'b0;
    #1;
    check_eq("ar_valid",     32'(bus.valid),     0);
    check_eq("ar_addr",      32'(bus.addr),      0);
    check_eq("ar_busy",      32'(busy),          0);
    check_eq("ar_cmd_ready", 32'(bus.cmd_ready), 0);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ar_after_valid", 32'(bus.valid), 0);
      check_eq("ar_after_busy",  32'(busy),      0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/mem_cmd_issuer.md
Name: mem_cmd_issuer

Overview:
- Upstream request stage that feeds the memory block's valid/ready port (valid, wr_rd, addr, wdata in; ready, rdata out).
- Buffers producer commands in a small FIFO and issues them one at a time under the memory handshake.
- Returns read data on a response channel with its own valid/ready.
- A watchdog drops any request the memory leaves unanswered.

Parameters:
WIDTH, 16, data width; must match memory WIDTH
DEPTH, 32, memory depth in words (informational; addr range check)
ADDR_WIDTH, 5, address width; must match memory ADDR_WIDTH
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 16, max cycles in REQ waiting for ready (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
cmd_valid  in  1  producer command valid
cmd_ready  out  1  FIFO can accept
cmd_wr_rd  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  command address
cmd_wdata  in  WIDTH  write data (ignored for reads)
valid  out  1  request to memory
wr_rd  out  1  request type to memory
addr  out  ADDR_WIDTH  request address to memory
wdata  out  WIDTH  request write data to memory
ready  in  1  memory accepts/completes request
rdata  in  WIDTH  memory read data, valid when ready=1 on a read
rsp_valid  out  1  read response valid
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  WIDTH  captured read data
rsp_addr  out  ADDR_WIDTH  address of captured read
timeout_err  out  1  one-cycle pulse when a request is dropped
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, FSM=IDLE, timer=0. All registered outputs 0: valid, wr_rd, addr, wdata, rsp_valid, rsp_rdata, rsp_addr, timeout_err. cmd_ready=0 and busy=0 while rst=0. Reset mid-transaction drops the in-flight request and all queued commands.
- cmd_ready = rst & (count<FIFO_DEPTH), combinational.
- Push on posedge with cmd_valid&cmd_ready. When full, no push, even if a pop occurs the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Count is ADDR-independent, width clog2(FIFO_DEPTH)+1.
- FSM IDLE: if count>0, pop head; register wr_rd/addr/wdata; valid=1; timer=0; go REQ.
  - Latency: command pushed at edge t appears on valid after edge t+1.
- FSM REQ: valid, wr_rd, addr, wdata held stable. timer increments each cycle.
  - ready=1, write: valid=0; go IDLE.
  - ready=1, read: rsp_rdata<=rdata, rsp_addr<=addr, rsp_valid=1, valid=0; go RESP.
  - ready=0 and timer==TIMEOUT-1: valid=0, timeout_err=1 for exactly one cycle, command discarded (no response); go IDLE.
  - ready seen on the same edge the timeout would fire: ready wins, no error.
- FSM RESP: rsp_valid and rsp_* held until an edge with rsp_ready=1; then rsp_valid=0; go IDLE. No new request is issued while in RESP. The FIFO still accepts pushes.
- ready while valid=0 is ignored.
- Back-to-back issue has one IDLE bubble cycle between requests.
- busy = (state!=IDLE) | (count!=0).
- In order: responses return in command order; writes produce no response.

Test Plan:
- Reset: hold rst=0 3 cycles with cmd_valid=1 -> all outputs 0, cmd_ready=0, no push. Release -> cmd_ready=1.
- Write then read: push W(addr=5, wdata=16'hA5A5) then R(addr=5); memory ready after 1 cycle.
  - valid rises after edge t+1 with wr_rd=1, addr=5.
  - Read then gives rsp_valid=1, rsp_rdata=16'hA5A5, rsp_addr=5.
- FIFO full: push 5 commands while ready=0 -> first pops into REQ, next 4 fill FIFO, cmd_ready=0.
  - Extra cmd_valid is not accepted.
  - After ready, order preserved.
- Timeout: read addr=3, ready held 0 -> valid drops after 16 cycles in REQ, timeout_err pulses 1 cycle, no rsp_valid, next command issues.
- Response backpressure: read completes with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, valid stays 0. rsp_ready=1 -> rsp_valid=0 next edge.
- Async reset mid-REQ: assert rst=0 while valid=1 -> valid=0 immediately (no clock edge), FIFO empty, busy=0.
